// File: rtl/port_alloc_st2_pkg.sv
// Shared sizes, types and bit helpers for the stage-2 port allocator.
// Per-channel vectors are packed channel-major: channel i occupies [i*W +: W].
package port_alloc_st2_pkg;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned NUM_OUT     = 4;
    localparam int unsigned PC_W        = 3;
    localparam int unsigned MAX_FLIT    = 5;
    localparam int unsigned DEFL_THRESH = 6;
    localparam int unsigned CH_W        = 2;
    localparam int unsigned CNT_W       = 3;

    typedef logic [NUM_OUT-1:0] port_vec_t;
    typedef logic [CH_W-1:0]    ch_idx_t;
    typedef logic [CNT_W-1:0]   starve_cnt_t;

    // Isolates the least-significant set bit; zero in gives zero out.
    function automatic port_vec_t lowest_one(input port_vec_t v);
        return v & (~v + port_vec_t'(1));
    endfunction

    function automatic logic [PC_W-1:0] popcount(input port_vec_t v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/port_alloc_pick.sv
// One link of the deflection priority chain: prefer a free productive port,
// otherwise fall back to the lowest free port.
module port_alloc_pick
    import port_alloc_st2_pkg::*;
(
    input  port_vec_t ppv_i,
    input  port_vec_t free_i,
    output port_vec_t port_o,
    output logic      prod_o
);

    port_vec_t prod_avail;

    always_comb begin
        prod_avail = ppv_i & free_i;
        if (prod_avail != '0) begin
            port_o = lowest_one(prod_avail);
            prod_o = 1'b1;
        end else begin
            port_o = lowest_one(free_i);
            prod_o = 1'b0;
        end
    end

endmodule

// File: rtl/port_alloc_st2.sv
// Stage-2 port allocator: overlap filter, deflection assignment with a round-robin
// pointer plus starvation override, multicast fork accounting; all outputs registered.
module port_alloc_st2
    import port_alloc_st2_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         valid_in,
    input  logic [NUM_CH-1:0]         mc_in,
    input  logic [NUM_CH*NUM_OUT-1:0] apv_p_in,
    input  logic [NUM_CH*NUM_OUT-1:0] ppv_p_in,
    input  logic [NUM_CH*PC_W-1:0]    numFlit_in,
    output logic [NUM_CH*NUM_OUT-1:0] apv_out,
    output logic [NUM_CH*NUM_OUT-1:0] ppv_rem_out,
    output logic [NUM_CH*PC_W-1:0]    numFlit_out,
    output logic [NUM_CH-1:0]         defl_out,
    output logic [NUM_CH-1:0]         noport_out,
    output logic [NUM_CH-1:0]         valid_out
);

    port_vec_t       apv_p [NUM_CH];
    port_vec_t       ppv_p [NUM_CH];
    port_vec_t       g     [NUM_CH];
    logic [PC_W-1:0] nf_in [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign apv_p[i] = apv_p_in[i*NUM_OUT +: NUM_OUT];
        assign ppv_p[i] = ppv_p_in[i*NUM_OUT +: NUM_OUT];
        assign nf_in[i] = numFlit_in[i*PC_W +: PC_W];
    end

    ch_idx_t     rr_q, rr_d;
    starve_cnt_t starve_q [NUM_CH];
    starve_cnt_t starve_d [NUM_CH];

    port_vec_t         claimed, overlap, free;
    logic [NUM_CH-1:0] cand;

    always_comb begin
        claimed = '0;
        overlap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            g[i] = '0;
            if (valid_in[i]) begin
                g[i]    = apv_p[i] & ~claimed;
                overlap = overlap | (apv_p[i] & claimed);
                claimed = claimed | apv_p[i];
            end
            cand[i] = valid_in[i] && (g[i] == '0);
        end
        free = ~claimed;
    end

    // Service order: lowest starved channel first (if any), then round-robin from rr_q.
    ch_idx_t order [NUM_CH];
    logic    has_st;
    ch_idx_t st_idx;

    always_comb begin
        ch_idx_t slot;
        ch_idx_t idx;
        has_st = 1'b0;
        st_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!has_st && starve_q[i] == CNT_W'(DEFL_THRESH)) begin
                has_st = 1'b1;
                st_idx = ch_idx_t'(i);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            order[k] = ch_idx_t'(k);
        end
        slot = '0;
        if (has_st) begin
            order[0] = st_idx;
            slot     = ch_idx_t'(1);
        end
        for (int j = 0; j < NUM_CH; j++) begin
            idx = rr_q + ch_idx_t'(j);
            if (!(has_st && idx == st_idx)) begin
                order[slot] = idx;
                slot        = slot + ch_idx_t'(1);
            end
        end
    end

    port_vec_t         slot_port [NUM_CH];
    logic [NUM_CH-1:0] slot_prod;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        port_vec_t free_in, port, free_nxt;
        logic      prod;

        if (k == 0) begin : g_first
            assign free_in = free;
        end else begin : g_next
            assign free_in = g_slot[k-1].free_nxt;
        end

        port_alloc_pick u_pick (
            .ppv_i  (ppv_p[order[k]]),
            .free_i (free_in),
            .port_o (port),
            .prod_o (prod)
        );

        assign slot_port[k] = cand[order[k]] ? port : '0;
        assign slot_prod[k] = prod;
        assign free_nxt     = free_in & ~slot_port[k];
    end

    port_vec_t                 apv_ch [NUM_CH];
    logic [NUM_CH-1:0]         defl_d, noport_d;
    logic [NUM_CH*NUM_OUT-1:0] apv_d, ppv_rem_d;
    logic [NUM_CH*PC_W-1:0]    nf_d;
    logic                      any_cand;
    ch_idx_t                   last_cand;

    always_comb begin
        logic [PC_W-1:0] sum;
        defl_d    = '0;
        noport_d  = '0;
        any_cand  = 1'b0;
        last_cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            apv_ch[i] = g[i];
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (cand[order[k]]) begin
                apv_ch[order[k]]   = slot_port[k];
                noport_d[order[k]] = (slot_port[k] == '0);
                defl_d[order[k]]   = (slot_port[k] != '0) && !slot_prod[k];
                any_cand           = 1'b1;
                last_cand          = order[k];
            end
        end
        rr_d = any_cand ? last_cand + ch_idx_t'(1) : rr_q;

        for (int i = 0; i < NUM_CH; i++) begin
            apv_d[i*NUM_OUT +: NUM_OUT]     = apv_ch[i];
            // Invalid slots carry no flit, so nothing is left to serve.
            ppv_rem_d[i*NUM_OUT +: NUM_OUT] = (valid_in[i] && mc_in[i]) ?
                                              (ppv_p[i] & ~apv_ch[i]) : '0;
            sum = nf_in[i] + popcount(apv_ch[i]) - PC_W'(apv_ch[i] != '0);
            if (mc_in[i]) begin
                nf_d[i*PC_W +: PC_W] = (sum > PC_W'(MAX_FLIT)) ? PC_W'(MAX_FLIT) : sum;
            end else begin
                nf_d[i*PC_W +: PC_W] = nf_in[i];
            end

            starve_d[i] = starve_q[i];
            if (valid_in[i]) begin
                if (defl_d[i] || noport_d[i]) begin
                    if (starve_q[i] != CNT_W'(DEFL_THRESH)) begin
                        starve_d[i] = starve_q[i] + starve_cnt_t'(1);
                    end
                end else begin
                    starve_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q        <= '0;
            apv_out     <= '0;
            ppv_rem_out <= '0;
            numFlit_out <= '0;
            defl_out    <= '0;
            noport_out  <= '0;
            valid_out   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            apv_out     <= apv_d;
            ppv_rem_out <= ppv_rem_d;
            numFlit_out <= nf_d;
            defl_out    <= defl_d;
            noport_out  <= noport_d;
            valid_out   <= valid_in;
            for (int i = 0; i < NUM_CH; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

    // Stage 1 should never hand the same port to two live flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (overlap == '0)
                else $error("port_alloc_st2: overlapping stage-1 grants %b", overlap);
        end
    end

endmodule

// File: tb/tb_port_alloc_st2.sv
// Directed plus randomized bench for port_alloc_st2 against a queue-based allocation model.
module tb_port_alloc_st2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  valid_in, mc_in;
    logic [15:0] apv_p_in, ppv_p_in;
    logic [11:0] numFlit_in;
    logic [15:0] apv_out, ppv_rem_out;
    logic [11:0] numFlit_out;
    logic [3:0]  defl_out, noport_out, valid_out;

    port_alloc_st2 dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .mc_in       (mc_in),
        .apv_p_in    (apv_p_in),
        .ppv_p_in    (ppv_p_in),
        .numFlit_in  (numFlit_in),
        .apv_out     (apv_out),
        .ppv_rem_out (ppv_rem_out),
        .numFlit_out (numFlit_out),
        .defl_out    (defl_out),
        .noport_out  (noport_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_chk = 0;
    int n_fail = 0;

    bit [3:0] t_v, t_mc;
    bit [3:0] t_ap [4];
    bit [3:0] t_pp [4];
    int       t_nf [4];

    int m_rr;
    int m_sc [4];

    logic [15:0] e_apv, e_rem;
    logic [11:0] e_nf;
    logic [3:0]  e_defl, e_np, e_v;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        t_v = '0;
        t_mc = '0;
        for (int i = 0; i < 4; i++) begin
            t_ap[i] = '0;
            t_pp[i] = '0;
            t_nf[i] = 0;
        end
    endtask

    task automatic drive();
        valid_in = t_v;
        mc_in    = t_mc;
        for (int i = 0; i < 4; i++) begin
            apv_p_in[i*4 +: 4]   = t_ap[i];
            ppv_p_in[i*4 +: 4]   = t_pp[i];
            numFlit_in[i*3 +: 3] = 3'(t_nf[i]);
        end
    endtask

    // Reference allocation: one cycle of the allocator rules, advancing m_rr/m_sc.
    task automatic model();
        bit [3:0] used, free, want, port;
        bit [3:0] apv [4];
        bit       cand [4];
        bit       defl [4];
        bit       np [4];
        bit       prod;
        int       order [$];
        int       st, last, c, s;
        used = 0;
        st = -1;
        last = -1;
        for (int i = 0; i < 4; i++) begin
            apv[i] = 0;
            defl[i] = 0;
            np[i] = 0;
            if (t_v[i]) begin
                apv[i] = t_ap[i] & ~used;
                used = used | t_ap[i];
            end
            cand[i] = t_v[i] && (apv[i] == 0);
            if (st < 0 && m_sc[i] == 6) st = i;
        end
        free = ~used;
        if (st >= 0) order.push_back(st);
        for (int j = 0; j < 4; j++) begin
            c = (m_rr + j) % 4;
            if (c != st) order.push_back(c);
        end
        for (int k = 0; k < order.size(); k++) begin
            c = order[k];
            if (cand[c]) begin
                last = c;
                want = t_pp[c] & free;
                prod = (want != 0);
                if (!prod) want = free;
                if (want == 0) begin
                    np[c] = 1;
                end else begin
                    port = 0;
                    for (int p = 3; p >= 0; p--) if (want[p]) port = 4'(1 << p);
                    apv[c] = port;
                    free = free & ~port;
                    defl[c] = !prod;
                end
            end
        end
        if (last >= 0) m_rr = (last + 1) % 4;
        for (int i = 0; i < 4; i++) begin
            if (t_v[i]) m_sc[i] = (defl[i] || np[i]) ? ((m_sc[i] < 6) ? m_sc[i] + 1 : 6) : 0;
            e_apv[i*4 +: 4] = apv[i];
            e_rem[i*4 +: 4] = (t_v[i] && t_mc[i]) ? (t_pp[i] & ~apv[i]) : 4'b0;
            s = t_nf[i];
            if (t_mc[i]) begin
                s = t_nf[i] + $countones(apv[i]) - ((apv[i] != 0) ? 1 : 0);
                if (s > 5) s = 5;
            end
            e_nf[i*3 +: 3] = 3'(s);
            e_defl[i] = defl[i];
            e_np[i] = np[i];
        end
        e_v = t_v;
    endtask

    task automatic apply();
        drive();
        model();
        n_vec++;
        @(posedge clk);
        #1;
        chk("apv", apv_out, e_apv);
        chk("ppv_rem", ppv_rem_out, e_rem);
        chk("numflit", 16'(numFlit_out), 16'(e_nf));
        chk("defl", 16'(defl_out), 16'(e_defl));
        chk("noport", 16'(noport_out), 16'(e_np));
        chk("valid", 16'(valid_out), 16'(e_v));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_apv"}, apv_out, 16'h0);
        chk({tag, "_rem"}, ppv_rem_out, 16'h0);
        chk({tag, "_nf"}, 16'(numFlit_out), 16'h0);
        chk({tag, "_defl"}, 16'(defl_out), 16'h0);
        chk({tag, "_noport"}, 16'(noport_out), 16'h0);
        chk({tag, "_valid"}, 16'(valid_out), 16'h0);
    endtask

    initial begin
        m_rr = 0;
        for (int i = 0; i < 4; i++) m_sc[i] = 0;
        clear_in();
        drive();
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Unicast, no conflict
        clear_in();
        t_v = 4'hF;
        t_ap[0] = 4'b0001; t_ap[1] = 4'b0010; t_ap[2] = 4'b0100; t_ap[3] = 4'b1000;
        for (int i = 0; i < 4; i++) t_nf[i] = i;
        apply();
        chk("uc_apv_lit", apv_out, 16'h8421);
        chk("uc_nf_lit", 16'(numFlit_out), 16'(12'b011_010_001_000));

        // Single deflection
        clear_in();
        t_v = 4'b0011;
        t_ap[0] = 4'b0001;
        t_pp[1] = 4'b0001;
        apply();
        chk("sd_apv1_lit", 16'(apv_out[7:4]), 16'h2);
        chk("sd_defl_lit", 16'(defl_out), 16'h2);

        // Multicast fork
        clear_in();
        t_v = 4'b0001; t_mc = 4'b0001;
        t_ap[0] = 4'b0011; t_pp[0] = 4'b0100; t_nf[0] = 1;
        apply();
        chk("mc_rem_lit", 16'(ppv_rem_out[3:0]), 16'h4);
        chk("mc_nf_lit", 16'(numFlit_out[2:0]), 16'h2);

        // Port exhaustion
        clear_in();
        t_v = 4'b0011; t_mc = 4'b0001;
        t_ap[0] = 4'b1111;
        apply();
        chk("ex_noport_lit", 16'(noport_out), 16'h2);
        chk("ex_apv1_lit", 16'(apv_out[7:4]), 16'h0);

        // Starvation: ch3 deflected six times in a row
        for (int n = 0; n < 6; n++) begin
            clear_in();
            t_v = 4'b1001;
            t_ap[0] = 4'b0001;
            t_pp[3] = 4'b0001;
            apply();
            chk("st_defl_lit", 16'(defl_out), 16'h8);
        end
        // ch1 alone deflected, leaving rr_ptr at 2 while ch3 sits at threshold
        clear_in();
        t_v = 4'b0011;
        t_ap[0] = 4'b0001;
        apply();
        // ch2/ch3 contend for the single free port 0100; starved ch3 must win
        clear_in();
        t_v = 4'hF; t_mc = 4'b0010;
        t_ap[0] = 4'b0001; t_ap[1] = 4'b1010;
        t_pp[2] = 4'b0100; t_pp[3] = 4'b0001;
        apply();
        chk("ov_apv3_lit", 16'(apv_out[15:12]), 16'h4);
        chk("ov_noport_lit", 16'(noport_out), 16'h4);
        // ch3 served productively, clearing its count
        clear_in();
        t_v = 4'b1001;
        t_ap[0] = 4'b0001;
        t_pp[3] = 4'b0100;
        apply();
        chk("pr_defl_lit", 16'(defl_out), 16'h0);
        // Same contention again: without the override, rr order lets ch2 win
        clear_in();
        t_v = 4'hF; t_mc = 4'b0010;
        t_ap[0] = 4'b0001; t_ap[1] = 4'b1010;
        t_pp[2] = 4'b0100; t_pp[3] = 4'b0100;
        apply();
        chk("cl_noport_lit", 16'(noport_out), 16'h8);

        // Randomized traffic with disjoint stage-1 grants
        for (int n = 0; n < 300; n++) begin
            int o;
            clear_in();
            for (int p = 0; p < 4; p++) begin
                o = $urandom_range(0, 5);
                if (o < 4) t_ap[o][p] = 1'b1;
            end
            t_v = 4'($urandom);
            t_mc = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                t_pp[i] = 4'($urandom) & ~t_ap[i];
                t_nf[i] = $urandom_range(0, 3);
            end
            apply();
        end

        // Async reset mid-stream; first set ch0 as last candidate so rr_ptr would be 1
        clear_in();
        t_v = 4'b0011;
        t_ap[1] = 4'b0001;
        apply();
        clear_in();
        t_v = 4'hF; t_mc = 4'hF;
        t_ap[0] = 4'b0011; t_pp[1] = 4'b0100;
        drive();
        #3;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        m_rr = 0;
        for (int i = 0; i < 4; i++) m_sc[i] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_in();
        t_v = 4'b0111;
        t_ap[1] = 4'b1110;
        t_pp[0] = 4'b0001; t_pp[2] = 4'b0001;
        apply();
        chk("pr_noport_lit", 16'(noport_out), 16'h4);
        chk("pr_apv0_lit", 16'(apv_out[3:0]), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
